// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 9600/115200 baud, 7/8 data bits,
// optional even parity, one-entry hold register with sticky overrun flag.
module uart_tx #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] letter,
    input  logic       baudr,
    input  logic       ps,
    input  logic       dlr,
    input  logic       clrovr,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       done,
    output logic       overrun
);
    localparam int DIV_LO = (CLK_HZ + 4800) / 9600;
    localparam int DIV_HI = (CLK_HZ + 57600) / 115200;
    localparam int CW     = (DIV_LO > 1) ? $clog2(DIV_LO) : 1;
    localparam logic [CW-1:0] LO_M1 = CW'(DIV_LO - 1);
    localparam logic [CW-1:0] HI_M1 = CW'(DIV_HI - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          f_baud_q, f_baud_d;
    logic          f_ps_q, f_ps_d;
    logic          f_dlr_q, f_dlr_d;
    logic [7:0]    hold_q, hold_d;
    logic          h_baud_q, h_baud_d;
    logic          h_ps_q, h_ps_d;
    logic          h_dlr_q, h_dlr_d;
    logic          full_q, full_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic          tick;
    logic          load;
    logic [2:0]    last_bit;

    assign tick     = cnt_q == (f_baud_q ? HI_M1 : LO_M1);
    assign last_bit = f_dlr_q ? 3'd7 : 3'd6;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        f_baud_d = f_baud_q;
        f_ps_d   = f_ps_q;
        f_dlr_d  = f_dlr_q;
        hold_d   = hold_q;
        h_baud_d = h_baud_q;
        h_ps_d   = h_ps_q;
        h_dlr_d  = h_dlr_q;
        full_d   = full_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
        load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = full_q;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bit_q == last_bit) begin
                        state_d = f_ps_q ? PARITY : STOP;
                        tx_d    = f_ps_q ? par_q : 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    load    = full_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Hold register drains into the shifter and starts a new frame
        if (load) begin
            state_d  = START;
            tx_d     = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
            shift_d  = hold_q;
            par_d    = h_dlr_q ? ^hold_q : ^hold_q[6:0];
            f_baud_d = h_baud_q;
            f_ps_d   = h_ps_q;
            f_dlr_d  = h_dlr_q;
            full_d   = 1'b0;
        end

        if (clrovr) begin
            ovr_d = 1'b0;
        end

        // A write is judged against the pre-edge full flag
        if (wr) begin
            if (full_q) begin
                ovr_d = 1'b1;
            end else begin
                hold_d   = letter;
                h_baud_d = baudr;
                h_ps_d   = ps;
                h_dlr_d  = dlr;
                full_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            f_baud_q <= 1'b0;
            f_ps_q   <= 1'b0;
            f_dlr_q  <= 1'b0;
            hold_q   <= '0;
            h_baud_q <= 1'b0;
            h_ps_q   <= 1'b0;
            h_dlr_q  <= 1'b0;
            full_q   <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            f_baud_q <= f_baud_d;
            f_ps_q   <= f_ps_d;
            f_dlr_q  <= f_dlr_d;
            hold_q   <= hold_d;
            h_baud_q <= h_baud_d;
            h_ps_q   <= h_ps_d;
            h_dlr_q  <= h_dlr_d;
            full_q   <= full_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = state_q != IDLE;
    assign full    = full_q;
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule
